// File: rtl/branch_predict_unit.sv
// Combined direction predictor and BTB with bimodal or gshare PHT indexing,
// a speculative global history register with repair, and resolve counters.
module branch_predict_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 8,
    parameter int unsigned GHR_BITS   = 6,
    parameter int unsigned MODE       = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                lookup_valid_i,
    input  logic [XLEN-1:0]     lookup_pc_i,
    output logic                pred_hit_o,
    output logic                pred_taken_o,
    output logic [XLEN-1:0]     pred_target_o,
    output logic [GHR_BITS-1:0] pred_ghr_o,
    input  logic                upd_valid_i,
    input  logic [XLEN-1:0]     upd_pc_i,
    input  logic                upd_is_jump_i,
    input  logic                upd_taken_i,
    input  logic [XLEN-1:0]     upd_target_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,
    input  logic                upd_mispredict_i,
    output logic [31:0]         branch_count_o,
    output logic [31:0]         mispredict_count_o
);
    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam bit          Gshare  = (MODE == 1);

    logic [1:0]          pht_q        [Entries];
    logic [Entries-1:0]  btb_valid_q;
    logic [Entries-1:0]  btb_jump_q;
    logic [TAG_BITS-1:0] btb_tag_q    [Entries];
    logic [XLEN-1:0]     btb_target_q [Entries];

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         branch_count_q, branch_count_d;
    logic [31:0]         mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] lk_btb_idx, lk_pht_idx, upd_btb_idx, upd_pht_idx;
    logic [INDEX_BITS-1:0] lk_ghr_ext, upd_ghr_ext;
    logic [TAG_BITS-1:0]   lk_tag, upd_tag;
    logic                  lk_hit, lk_jump;
    logic [1:0]            pht_cur, pht_next;
    logic [GHR_BITS:0]     repair_shift, spec_shift;

    assign lk_btb_idx  = lookup_pc_i[INDEX_BITS+1:2];
    assign lk_tag      = lookup_pc_i[INDEX_BITS+2 +: TAG_BITS];
    assign upd_btb_idx = upd_pc_i[INDEX_BITS+1:2];
    assign upd_tag     = upd_pc_i[INDEX_BITS+2 +: TAG_BITS];

    always_comb begin
        lk_ghr_ext                 = '0;
        upd_ghr_ext                = '0;
        lk_ghr_ext[GHR_BITS-1:0]   = ghr_q;
        upd_ghr_ext[GHR_BITS-1:0]  = upd_ghr_i;
        lk_pht_idx                 = Gshare ? (lk_btb_idx ^ lk_ghr_ext) : lk_btb_idx;
        upd_pht_idx                = Gshare ? (upd_btb_idx ^ upd_ghr_ext) : upd_btb_idx;
    end

    // Gating by rst_ni makes the reset cycle present a clean miss.
    assign lk_hit  = rst_ni & btb_valid_q[lk_btb_idx] & (btb_tag_q[lk_btb_idx] == lk_tag);
    assign lk_jump = btb_jump_q[lk_btb_idx];

    assign pred_hit_o    = lk_hit;
    assign pred_taken_o  = lk_hit & (lk_jump | pht_q[lk_pht_idx][1]);
    assign pred_target_o = pred_taken_o ? btb_target_q[lk_btb_idx] : lookup_pc_i + XLEN'(4);
    assign pred_ghr_o    = rst_ni ? ghr_q : '0;

    always_comb begin
        pht_cur  = pht_q[upd_pht_idx];
        pht_next = pht_cur;
        if (upd_taken_i) begin
            if (pht_cur != 2'b11) pht_next = pht_cur + 2'b01;
        end else begin
            if (pht_cur != 2'b00) pht_next = pht_cur - 2'b01;
        end
    end

    // Repair from the carried snapshot beats the speculative shift of this cycle's lookup.
    always_comb begin
        repair_shift = {upd_ghr_i, upd_taken_i};
        spec_shift   = {ghr_q, pred_taken_o};
        ghr_d        = ghr_q;
        if (upd_valid_i && upd_mispredict_i) begin
            ghr_d = upd_is_jump_i ? upd_ghr_i : repair_shift[GHR_BITS-1:0];
        end else if (lookup_valid_i && lk_hit && !lk_jump) begin
            ghr_d = spec_shift[GHR_BITS-1:0];
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_valid_i) begin
            branch_count_d = branch_count_q + 32'd1;
            if (upd_mispredict_i) mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            btb_valid_q        <= '0;
            for (int i = 0; i < Entries; i++) pht_q[i] <= 2'b01;
        end else begin
            ghr_q              <= ghr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            if (upd_valid_i && !upd_is_jump_i) pht_q[upd_pht_idx] <= pht_next;
            if (upd_valid_i && upd_taken_i) btb_valid_q[upd_btb_idx] <= 1'b1;
        end
    end

    // Payload needs no reset; the valid bits guard it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && upd_valid_i && upd_taken_i) begin
            btb_tag_q[upd_btb_idx]    <= upd_tag;
            btb_target_q[upd_btb_idx] <= upd_target_i;
            btb_jump_q[upd_btb_idx]   <= upd_is_jump_i;
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc_i;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: bimodal instance u_bim and gshare instance u_gsh share all stimulus.
module tb_branch_predict_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lookup_valid_i;
    logic [31:0] lookup_pc_i;
    logic        upd_valid_i, upd_is_jump_i, upd_taken_i, upd_mispredict_i;
    logic [31:0] upd_pc_i, upd_target_i;
    logic [5:0]  upd_ghr_i;

    logic        hit0, taken0, hit1, taken1;
    logic [31:0] tgt0, tgt1, bc0, bc1, mc0, mc1;
    logic [5:0]  ghr0, ghr1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    branch_predict_unit #(.MODE(0)) u_bim (
        .clk_i(clk_i), .rst_ni(rst_ni), .lookup_valid_i(lookup_valid_i),
        .lookup_pc_i(lookup_pc_i), .pred_hit_o(hit0), .pred_taken_o(taken0),
        .pred_target_o(tgt0), .pred_ghr_o(ghr0), .upd_valid_i(upd_valid_i),
        .upd_pc_i(upd_pc_i), .upd_is_jump_i(upd_is_jump_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_ghr_i(upd_ghr_i),
        .upd_mispredict_i(upd_mispredict_i), .branch_count_o(bc0), .mispredict_count_o(mc0)
    );

    branch_predict_unit #(.MODE(1)) u_gsh (
        .clk_i(clk_i), .rst_ni(rst_ni), .lookup_valid_i(lookup_valid_i),
        .lookup_pc_i(lookup_pc_i), .pred_hit_o(hit1), .pred_taken_o(taken1),
        .pred_target_o(tgt1), .pred_ghr_o(ghr1), .upd_valid_i(upd_valid_i),
        .upd_pc_i(upd_pc_i), .upd_is_jump_i(upd_is_jump_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_ghr_i(upd_ghr_i),
        .upd_mispredict_i(upd_mispredict_i), .branch_count_o(bc1), .mispredict_count_o(mc1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                       input logic [31:0] tgt, input logic [5:0] g, input logic misp);
        upd_valid_i      = 1'b1;
        upd_pc_i         = pc;
        upd_is_jump_i    = jmp;
        upd_taken_i      = tkn;
        upd_target_i     = tgt;
        upd_ghr_i        = g;
        upd_mispredict_i = misp;
        step();
        upd_valid_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc_i = pc;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; lookup_valid_i = 1'b0; lookup_pc_i = '0;
        upd_valid_i = 1'b0; upd_is_jump_i = 1'b0; upd_taken_i = 1'b0;
        upd_mispredict_i = 1'b0; upd_pc_i = '0; upd_target_i = '0; upd_ghr_i = '0;

        // Outputs during the reset cycle itself
        look(32'h100);
        check("rst_hit", hit0, 0);
        check("rst_taken", taken0, 0);
        check("rst_target", tgt0, 32'h104);
        check("rst_ghr", ghr0, 0);
        step(); step();
        rst_ni = 1'b1;
        look(32'h100);
        check("rst_bc", bc0, 0);
        check("rst_mc", mc0, 0);
        check("post_rst_hit", hit0, 0);

        // Bimodal: two taken updates drive counter 01 -> 11
        upd(32'h100, 0, 1, 32'h80, 0, 0);
        upd(32'h100, 0, 1, 32'h80, 0, 0);
        look(32'h100);
        check("bim_hit", hit0, 1);
        check("bim_taken", taken0, 1);
        check("bim_target", tgt0, 32'h80);
        check("bim_bc", bc0, 2);

        // Saturation: four not-taken reach 00, fifth stays at 00
        for (int i = 0; i < 4; i++) upd(32'h100, 0, 0, 32'h0, 0, 0);
        look(32'h100);
        check("sat_taken", taken0, 0);
        check("sat_target", tgt0, 32'h104);
        check("sat_hit", hit0, 1);
        upd(32'h100, 0, 0, 32'h0, 0, 0);
        upd(32'h100, 0, 1, 32'h80, 0, 0);
        look(32'h100);
        check("sat_floor", taken0, 0);
        upd(32'h100, 0, 1, 32'h80, 0, 0);
        look(32'h100);
        check("sat_up2", taken0, 1);
        check("sat_bc", bc0, 9);

        // Jump entry: always taken, PHT untouched, no GHR shift on lookup
        upd(32'h204, 1, 1, 32'h400, 0, 0);
        look(32'h204);
        check("jmp_taken", taken0, 1);
        check("jmp_target", tgt0, 32'h400);
        lookup_valid_i = 1'b1;
        step();
        lookup_valid_i = 1'b0;
        #1;
        check("jmp_no_shift", ghr0, 0);
        upd(32'h204, 0, 1, 32'h300, 0, 0);
        upd(32'h204, 0, 0, 32'h0, 0, 0);
        look(32'h204);
        check("jmp_pht_hit", hit0, 1);
        check("jmp_pht_clean", taken0, 0);
        check("jmp_pht_target", tgt0, 32'h208);

        // Aliasing: same index, different tag misses
        upd(32'h100, 0, 1, 32'h80, 0, 0);
        look(32'h200);
        check("alias_hit", hit0, 0);
        check("alias_target", tgt0, 32'h204);

        // Read-during-write returns old entry, new one visible next cycle
        lookup_valid_i = 1'b1;
        lookup_pc_i = 32'h100;
        upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_is_jump_i = 1'b1;
        upd_taken_i = 1'b1; upd_target_i = 32'h500; upd_ghr_i = '0;
        #1;
        check("rdw_old", tgt0, 32'h80);
        step();
        upd_valid_i = 1'b0; lookup_valid_i = 1'b0;
        #1;
        check("rdw_new", tgt0, 32'h500);
        check("rdw_bc", bc0, 14);
        check("rdw_mc", mc0, 0);

        // Gshare repair: build GHR 000111 speculatively, then repair wins
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        upd(32'h100, 0, 1, 32'h80, 6'd0, 0);
        upd(32'h100, 0, 1, 32'h80, 6'd1, 0);
        upd(32'h100, 0, 1, 32'h80, 6'd3, 0);
        lookup_valid_i = 1'b1;
        lookup_pc_i = 32'h100;
        step(); step(); step();
        check("gsh_spec", ghr1, 6'b000111);
        upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_is_jump_i = 1'b0; upd_taken_i = 1'b1;
        upd_target_i = 32'h80; upd_ghr_i = 6'b000010; upd_mispredict_i = 1'b1;
        #1;
        check("gsh_concurrent_hit", hit1, 1);
        step();
        upd_valid_i = 1'b0; upd_mispredict_i = 1'b0; lookup_valid_i = 1'b0;
        #1;
        check("gsh_repair", ghr1, 6'b000101);
        check("gsh_mc", mc1, 1);
        upd(32'h200, 1, 1, 32'h400, 6'b101010, 1);
        #1;
        check("gsh_jmp_repair", ghr1, 6'b101010);
        check("gsh_mc2", mc1, 2);
        check("gsh_bc", bc1, 5);

        // Reset overrides a same-cycle update
        rst_ni = 1'b0;
        upd_valid_i = 1'b1; upd_pc_i = 32'h200; upd_is_jump_i = 1'b0; upd_taken_i = 1'b1;
        upd_target_i = 32'h600; upd_mispredict_i = 1'b1;
        step();
        rst_ni = 1'b1; upd_valid_i = 1'b0; upd_mispredict_i = 1'b0;
        look(32'h200);
        check("rst_upd_bc", bc0, 0);
        check("rst_upd_mc", mc1, 0);
        check("rst_upd_ghr", ghr1, 0);
        check("rst_upd_hit", hit0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised branch prediction unit for the five-stage rv32i pipeline. It replaces the separate local-history and target-buffer blocks with one unit. It provides a combined direction predictor and branch target buffer, with selectable bimodal or gshare indexing, a speculative global history register with misprediction repair, and performance counters. The IF stage issues lookups; the MEM stage, where branches resolve, drives updates.

Parameters:
XLEN, 32, address/target width
INDEX_BITS, 6, log2 of entries (2^INDEX_BITS PHT counters and BTB entries)
TAG_BITS, 8, BTB tag width, taken from pc[INDEX_BITS+2 +: TAG_BITS]
GHR_BITS, 6, global history length (1..INDEX_BITS)
MODE, 0, 0 = bimodal (PC index), 1 = gshare (PC index XOR GHR)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
lookup_valid  in  1  IF-stage lookup this cycle
lookup_pc  in  XLEN  fetch PC
pred_hit  out  1  BTB tag match on lookup_pc
pred_taken  out  1  predicted taken
pred_target  out  XLEN  next fetch PC
pred_ghr  out  GHR_BITS  GHR value used for this lookup; carried down the pipe
upd_valid  in  1  resolved control transfer from MEM
upd_pc  in  XLEN  PC of resolved instruction
upd_is_jump  in  1  1 = jal/jalr, 0 = conditional branch
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target
upd_ghr  in  GHR_BITS  pred_ghr snapshot carried with the instruction
upd_mispredict  in  1  direction or target mispredicted
branch_count  out  32  resolved updates since reset
mispredict_count  out  32  mispredictions since reset

Behaviour:
- Reset, synchronous on rst_n=0:
  - all BTB valid bits cleared
  - all PHT counters set to 2'b01 (weakly not-taken)
  - GHR cleared to 0
  - branch_count and mispredict_count cleared to 0
  - in the reset cycle, outputs reflect reset state: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, pred_ghr=0
- Lookup: combinational, 0-cycle latency from array state.
  - idx = pc[INDEX_BITS+1:2] in MODE 0
  - idx = pc[INDEX_BITS+1:2] XOR {zero-extended GHR} in MODE 1
  - BTB is always indexed by pc[INDEX_BITS+1:2]
  - pred_hit = valid & tag match
  - pred_taken = pred_hit & (entry.is_jump | pht[idx][1])
  - pred_target = pred_taken ? entry.target : lookup_pc+4, with XLEN wrap
  - pred_ghr = current GHR
- Read-during-write: a lookup in the same cycle as an update to the same entry returns the old contents.
- Update, on an edge with upd_valid=1:
  - Index uses upd_pc; in MODE 1 it is XORed with upd_ghr, not the live GHR.
  - Conditional branches only: the PHT counter saturates, +1 if taken (max 11) and -1 if not (min 00).
  - upd_taken=1: the BTB entry is written with valid=1, tag, upd_target and upd_is_jump.
  - upd_taken=0: the BTB is not modified.
  - branch_count increments by 1 and wraps at 2^32.
  - mispredict_count increments when upd_mispredict=1 and wraps.
  - upd_mispredict is ignored when upd_valid=0.
- GHR, priority high to low:
  1. upd_valid & upd_mispredict & !upd_is_jump: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken} (repair)
  2. upd_valid & upd_mispredict & upd_is_jump: GHR <= upd_ghr
  3. lookup_valid & pred_hit & !entry.is_jump: GHR <= {GHR[GHR_BITS-2:0], pred_taken} (speculative shift)
  4. otherwise hold
- A simultaneous mispredict and lookup applies the repair only; the lookup is not shifted in.
- Reset asserted mid-operation discards any same-cycle update; the reset values win.
- No stall input. The pipeline deasserts lookup_valid while stalled, so a held fetch does not shift the GHR twice.

Test Plan:
- Reset then lookup pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_ghr=0; both counters 0.
- MODE 0: update pc=0x100 cond taken target=0x80 twice -> lookup 0x100 gives hit=1, taken=1 (counter 11), target=0x80; branch_count=2.
- Saturation: four not-taken updates on 0x100 after the step above -> counter 00, pred_taken=0, pred_target=0x104, hit still 1; a fifth keeps the counter at 00.
- Jump: update pc=0x200 is_jump=1 taken target=0x400 -> lookup 0x200 gives taken=1, target=0x400; PHT unaffected; GHR not shifted on that lookup.
- GHR repair (MODE 1, GHR_BITS=6): speculative shifts give GHR=6'b000111; same cycle, lookup hit plus update mispredict with upd_ghr=6'b000010, upd_taken=1 -> next GHR=6'b000101 (no speculative shift); mispredict_count increments.
- Aliasing/tag: update pc=0x100 taken, then lookup pc=0x100+(1<<(INDEX_BITS+2)) (same index, different tag) -> pred_hit=0, target=pc+4; a same-cycle write/read of one entry returns the old data.
